// File: rtl/qam16_pkg.sv
// Shared QAM16 definitions: FSM states, Gray-coded constellation levels and
// the 2-bit-to-level mapping. The receiver-side demapper uses the same table.
package qam16_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Constellation levels in units of the amplitude parameter
    localparam logic signed [2:0] LVL_M3 = -3'sd3;
    localparam logic signed [2:0] LVL_M1 = -3'sd1;
    localparam logic signed [2:0] LVL_P1 = 3'sd1;
    localparam logic signed [2:0] LVL_P3 = 3'sd3;

    // Gray mapping: adjacent levels differ in a single bit
    function automatic logic signed [2:0] gray_level(input logic [1:0] bits);
        case (bits)
            2'b00:   return LVL_M3;
            2'b01:   return LVL_M1;
            2'b11:   return LVL_P1;
            default: return LVL_P3;
        endcase
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with registered occupancy count. The head entry is
// presented combinationally on rd_data_o. Because empty_o comes from the
// registered count, a word written at an edge is never readable at that same
// edge. DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             wr_fire;
    logic             rd_fire;

    assign full_o    = (count_q == (AW+1)'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign wr_fire   = wr_en_i && !full_o;
    assign rd_fire   = rd_en_i && !empty_o;
    assign rd_data_o = mem_q[rd_ptr_q];

    // Storage array; contents need no reset since the count gates visibility
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    // Pointers and occupancy; a simultaneous write and read leaves count unchanged
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_fire) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (rd_fire) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({wr_fire, rd_fire})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/qam16_tx_mapper.sv
// QAM16 transmit mapper: buffers 4-bit symbols, maps each to Gray-coded I/Q
// levels and upsamples by 4 (zero-stuffed or held), marking the first sample
// of every symbol with sync and flagging symbol slots that end with no data.
module qam16_tx_mapper
    import qam16_pkg::*;
#(
    parameter logic signed [15:0] AMP    = 16'sd2048,
    parameter bit                 ZSTUFF = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         din,
    input  logic               din_valid,
    output logic               din_ready,
    output logic signed [15:0] di,
    output logic signed [15:0] dq,
    output logic               sync,
    output logic               busy,
    output logic               underrun
);

    state_t             state_q, state_d;
    logic [1:0]         ph_q, ph_d;
    logic signed [15:0] di_q, di_d;
    logic signed [15:0] dq_q, dq_d;
    logic               sync_q, sync_d;
    logic               underrun_q, underrun_d;

    logic               pop;
    logic [3:0]         head;
    logic               fifo_full;
    logic               fifo_empty;

    // Level times amplitude at full width, truncated to the 16-bit sample
    function automatic logic signed [15:0] scale(input logic [1:0] bits);
        logic signed [2:0]  lvl;
        logic signed [31:0] prod;
        lvl  = gray_level(bits);
        prod = $signed({{29{lvl[2]}}, lvl}) * $signed({{16{AMP[15]}}, AMP});
        return prod[15:0];
    endfunction

    sync_fifo #(
        .WIDTH (4),
        .DEPTH (4)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (din_valid),
        .wr_data_i (din),
        .rd_en_i   (pop),
        .rd_data_o (head),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    // Next-state logic: start or continue symbols on phase 3, otherwise step the phase
    always_comb begin
        state_d    = state_q;
        ph_d       = ph_q;
        di_d       = '0;
        dq_d       = '0;
        sync_d     = 1'b0;
        underrun_d = 1'b0;
        pop        = 1'b0;
        case (state_q)
            IDLE: begin
                ph_d = 2'd0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    di_d    = scale(head[3:2]);
                    dq_d    = scale(head[1:0]);
                    sync_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (ph_q != 2'd3) begin
                    ph_d = ph_q + 2'd1;
                    if (!ZSTUFF) begin
                        di_d = di_q;
                        dq_d = dq_q;
                    end
                end else if (!fifo_empty) begin
                    pop    = 1'b1;
                    di_d   = scale(head[3:2]);
                    dq_d   = scale(head[1:0]);
                    sync_d = 1'b1;
                    ph_d   = 2'd0;
                end else begin
                    state_d    = IDLE;
                    ph_d       = 2'd0;
                    underrun_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                ph_d    = 2'd0;
            end
        endcase
    end

    // State, phase and output sample registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ph_q       <= 2'd0;
            di_q       <= '0;
            dq_q       <= '0;
            sync_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ph_q       <= ph_d;
            di_q       <= di_d;
            dq_q       <= dq_d;
            sync_q     <= sync_d;
            underrun_q <= underrun_d;
        end
    end

    assign din_ready = !fifo_full;
    assign di        = di_q;
    assign dq        = dq_q;
    assign sync      = sync_q;
    assign underrun  = underrun_q;
    assign busy      = (state_q == RUN);

endmodule

// File: tb/tb_qam16_tx_mapper.sv
// Directed bench for qam16_tx_mapper. Two instances share all inputs: one
// zero-stuffing, one sample-and-hold, so every scenario checks both modes.
module tb_qam16_tx_mapper;

    logic               clk;
    logic               rst;
    logic [3:0]         din;
    logic               din_valid;
    logic               din_ready, din_ready_h;
    logic signed [15:0] di, dq, di_h, dq_h;
    logic               sync, sync_h;
    logic               busy, busy_h;
    logic               underrun, underrun_h;

    int passed;
    int total;

    // Hand-computed Gray levels at AMP=2048, indexed by the 2-bit field
    logic signed [15:0] lvl_tab [4] = '{-16'sd6144, -16'sd2048, 16'sd6144, 16'sd2048};

    logic [3:0] sym_vec [16];
    int         first_nr;
    int         prod_ticks;

    qam16_tx_mapper #(.AMP(16'sd2048), .ZSTUFF(1'b1)) dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .din_ready(din_ready), .di(di), .dq(dq), .sync(sync),
        .busy(busy), .underrun(underrun)
    );

    qam16_tx_mapper #(.AMP(16'sd2048), .ZSTUFF(1'b0)) dut_h (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .din_ready(din_ready_h), .di(di_h), .dq(dq_h), .sync(sync_h),
        .busy(busy_h), .underrun(underrun_h)
    );

    // 10 ns sample clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; din = 4'd0; din_valid = 1'b0;
        tick(); tick();
        total++; if (di !== 16'sd0 || dq !== 16'sd0) $display("[TB] FAIL reset_iq got %0d/%0d want 0/0", di, dq); else passed++;
        total++; if (sync !== 1'b0 || underrun !== 1'b0) $display("[TB] FAIL reset_flags got sync=%b und=%b want 0/0", sync, underrun); else passed++;
        total++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy got %b want 0", busy); else passed++;
        rst = 1'b0;
        tick();
        total++; if (din_ready !== 1'b1) $display("[TB] FAIL reset_ready got %b want 1", din_ready); else passed++;
    endtask

    task automatic test_single();
        din = 4'b1001; din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        total++; if (sync !== 1'b0 || busy !== 1'b0) $display("[TB] FAIL single_latency got sync=%b busy=%b want 0/0", sync, busy); else passed++;
        tick();
        total++; if (di !== 16'sd6144 || dq !== -16'sd2048 || sync !== 1'b1) $display("[TB] FAIL single_first got %0d/%0d sync=%b want 6144/-2048 sync=1", di, dq, sync); else passed++;
        total++; if (di_h !== 16'sd6144 || dq_h !== -16'sd2048 || sync_h !== 1'b1) $display("[TB] FAIL single_first_hold got %0d/%0d sync=%b want 6144/-2048 sync=1", di_h, dq_h, sync_h); else passed++;
        for (int p = 1; p < 4; p++) begin
            tick();
            total++; if (di !== 16'sd0 || dq !== 16'sd0 || sync !== 1'b0) $display("[TB] FAIL single_zero ph%0d got %0d/%0d sync=%b want 0/0 sync=0", p, di, dq, sync); else passed++;
            total++; if (di_h !== 16'sd6144 || dq_h !== -16'sd2048 || sync_h !== 1'b0) $display("[TB] FAIL single_hold ph%0d got %0d/%0d sync=%b want 6144/-2048 sync=0", p, di_h, dq_h, sync_h); else passed++;
        end
        tick();
        total++; if (underrun !== 1'b1 || busy !== 1'b0 || di !== 16'sd0) $display("[TB] FAIL single_underrun got und=%b busy=%b di=%0d want 1/0/0", underrun, busy, di); else passed++;
        tick();
        total++; if (underrun !== 1'b0) $display("[TB] FAIL single_underrun_pulse got %b want 0", underrun); else passed++;
    endtask

    // Producer offers sym_vec[0..n-1] with valid held high; consumer checks every sample
    task automatic run_stream(input int n, input string tag);
        prod_ticks = 0;
        first_nr   = -1;
        fork
            begin
                for (int i = 0; i < n; i++) begin
                    bit acc;
                    int tries;
                    acc = 1'b0;
                    tries = 0;
                    din = sym_vec[i];
                    din_valid = 1'b1;
                    while (!acc && tries < 40) begin
                        if (din_ready) acc = 1'b1;
                        else if (first_nr < 0) first_nr = prod_ticks;
                        tick();
                        prod_ticks++;
                        tries++;
                    end
                    total++; if (!acc) $display("[TB] FAIL %s_accept sym %0d got ready=0 want accepted", tag, i); else passed++;
                end
                din_valid = 1'b0;
            end
            begin
                int waited;
                logic [3:0] s;
                logic signed [15:0] ei, eq, wi, wq;
                waited = 0;
                while (!sync && waited < 12) begin
                    tick();
                    waited++;
                end
                total++; if (sync !== 1'b1) $display("[TB] FAIL %s_start got sync=%b want 1 within 12 cycles", tag, sync); else passed++;
                for (int k = 0; k < n; k++) begin
                    s  = sym_vec[k];
                    ei = lvl_tab[s[3:2]];
                    eq = lvl_tab[s[1:0]];
                    for (int p = 0; p < 4; p++) begin
                        wi = (p == 0) ? ei : 16'sd0;
                        wq = (p == 0) ? eq : 16'sd0;
                        total++;
                        if (di !== wi || dq !== wq || sync !== (p == 0) || underrun !== 1'b0 || di_h !== ei || dq_h !== eq)
                            $display("[TB] FAIL %s_sample sym%0d ph%0d got %0d/%0d sync=%b und=%b hold=%0d/%0d want %0d/%0d sync=%b und=0 hold=%0d/%0d",
                                     tag, k, p, di, dq, sync, underrun, di_h, dq_h, wi, wq, (p == 0), ei, eq);
                        else passed++;
                        tick();
                    end
                end
                total++; if (underrun !== 1'b1 || busy !== 1'b0) $display("[TB] FAIL %s_end got und=%b busy=%b want 1/0", tag, underrun, busy); else passed++;
            end
        join
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 16; i++) sym_vec[i] = 4'(i);
        run_stream(16, "b2b");
    endtask

    task automatic test_fill();
        sym_vec[0] = 4'hA; sym_vec[1] = 4'h3; sym_vec[2] = 4'hC;
        sym_vec[3] = 4'h5; sym_vec[4] = 4'hF; sym_vec[5] = 4'h0;
        run_stream(6, "fill");
        total++; if (first_nr != 5) $display("[TB] FAIL fill_ready_drop got cycle %0d want 5", first_nr); else passed++;
    endtask

    task automatic test_underrun_write();
        din = 4'b0011; din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        tick();
        total++; if (di !== -16'sd6144 || dq !== 16'sd2048 || sync !== 1'b1) $display("[TB] FAIL uw_first got %0d/%0d sync=%b want -6144/2048 sync=1", di, dq, sync); else passed++;
        tick(); tick(); tick();
        din = 4'b1110; din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        total++; if (underrun !== 1'b1 || busy !== 1'b0 || sync !== 1'b0 || di !== 16'sd0) $display("[TB] FAIL uw_underrun got und=%b busy=%b sync=%b di=%0d want 1/0/0/0", underrun, busy, sync, di); else passed++;
        tick();
        total++; if (di !== 16'sd2048 || dq !== 16'sd6144 || sync !== 1'b1 || busy !== 1'b1) $display("[TB] FAIL uw_second got %0d/%0d sync=%b busy=%b want 2048/6144 sync=1 busy=1", di, dq, sync, busy); else passed++;
        for (int i = 0; i < 5; i++) tick();
    endtask

    task automatic test_reset_mid();
        logic seen;
        for (int i = 0; i < 4; i++) begin
            din = 4'(i + 1); din_valid = 1'b1;
            tick();
        end
        din_valid = 1'b0;
        total++; if (busy !== 1'b1 || di_h !== -16'sd6144) $display("[TB] FAIL rm_running got busy=%b hold=%0d want 1/-6144", busy, di_h); else passed++;
        rst = 1'b1;
        tick();
        total++; if (di !== 16'sd0 || dq !== 16'sd0 || di_h !== 16'sd0 || dq_h !== 16'sd0 || sync !== 1'b0 || busy !== 1'b0) $display("[TB] FAIL rm_after got %0d/%0d hold=%0d/%0d sync=%b busy=%b want all 0", di, dq, di_h, dq_h, sync, busy); else passed++;
        rst = 1'b0;
        tick();
        total++; if (din_ready !== 1'b1) $display("[TB] FAIL rm_ready got %b want 1", din_ready); else passed++;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (sync || busy || sync_h || di_h !== 16'sd0) seen = 1'b1;
            tick();
        end
        total++; if (seen !== 1'b0) $display("[TB] FAIL rm_no_emit got activity=%b want 0", seen); else passed++;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_fill();
        test_underrun_write();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/qam16_tx_mapper.md
QAM16_TX_MAPPER -- requirements
Module: qam16_tx_mapper

Interface
REQ-001 Parameter: AMP, 16'sd2048, unit level; the ±1 constellation levels map to ±AMP and ±3 to ±3*AMP.
REQ-002 Parameter: ZSTUFF, 1, 1 = zero-stuffing upsample; 0 = sample-and-hold upsample.
REQ-003 Port: clk  in  1  sample clock, 4x symbol rate (4 MHz); single clock domain.
REQ-004 Port: rst  in  1  reset, synchronous, active-high.
REQ-005 Port: din  in  4  QAM16 symbol; bits[3:2] select I, bits[1:0] select Q.
REQ-006 Port: din_valid  in  1  din holds a symbol.
REQ-007 Port: din_ready  out  1  block can accept a symbol this cycle.
REQ-008 Port: di  out  16 signed  I baseband sample, one per clk.
REQ-009 Port: dq  out  16 signed  Q baseband sample, one per clk.
REQ-010 Port: sync  out  1  one-cycle pulse marking the first sample of each symbol (1 MHz while running).
REQ-011 Port: busy  out  1  high while in state RUN.
REQ-012 Port: underrun  out  1  one-cycle pulse when a symbol slot ends with the FIFO empty.

Function
REQ-013 A 4-entry FIFO SHALL buffer input symbols; din_ready = not full; a write occurs on a clk edge with din_valid && din_ready.
REQ-014 Gray mapping per 2-bit field SHALL be 00 -> -3*AMP, 01 -> -AMP, 11 -> +AMP, 10 -> +3*AMP; the product SHALL be computed at full width and truncated to 16 bits signed (±6144 at default AMP).
REQ-015 The state machine SHALL have two states, IDLE and RUN, plus a 2-bit phase counter ph.
REQ-016 IDLE: di=dq=0, sync=0, and ph held at 0. At an edge where the FIFO is non-empty, the FSM SHALL pop the head, register the mapped I/Q onto di/dq, pulse sync=1, set ph=0 and enter RUN.
REQ-017 Latency: a symbol written into an empty FIFO at edge k while in IDLE SHALL appear on di/dq with sync=1 after edge k+1.
REQ-018 RUN, ph=0..2 edge: ph SHALL increment and sync SHALL go to 0. di/dq SHALL take 0 if ZSTUFF=1, or hold the current symbol value if ZSTUFF=0.
REQ-019 RUN, ph=3 edge, FIFO non-empty: the FSM SHALL pop the next symbol, emit it with sync=1, set ph=0 and stay in RUN (gapless symbol stream).
REQ-020 RUN, ph=3 edge, FIFO empty: the FSM SHALL enter IDLE with di=dq=0 and sync=0, and pulse underrun for one cycle.
REQ-021 There SHALL be no write-to-read bypass: a symbol written at the same edge as a pop attempt on an empty FIFO is not visible; this case is an underrun, and the symbol is emitted on the next IDLE->RUN edge.
REQ-022 A simultaneous write and pop on a non-empty, non-full FIFO SHALL leave the count unchanged; a write when full SHALL be impossible (din_ready=0).
REQ-023 Each symbol SHALL occupy exactly 4 consecutive output samples; sync SHALL be asserted only on the first of them.

Reset
REQ-024 While rst=1 at an edge: FIFO flushed (count 0), state IDLE, ph=0, di=dq=0, sync=0, underrun=0, busy=0; din_ready SHALL read 1 the cycle after reset releases.
REQ-025 Reset asserted mid-symbol SHALL abort that symbol and discard all buffered symbols; no partial symbol SHALL be emitted after release.

Structure
REQ-026 Package qam16_pkg SHALL hold the state enum (IDLE, RUN), the Gray level constants (-3, -1, +1, +3) and the 2-bit-to-level mapping function, shared with receiver-side demapping.
REQ-027 The FIFO SHALL be a separate sub-module, sync_fifo (parameterised width 4, depth 4, synchronous active-high rst); the mapper, FSM and phase counter remain in qam16_tx_mapper.

Verification
REQ-028 Reset release, single symbol 4'b1001 -> after 1 cycle: di=+6144, dq=-2048, sync=1; next 3 cycles di=dq=0 (ZSTUFF=1); then underrun pulse, busy=0.
REQ-029 Same stimulus with ZSTUFF=0 -> di=+6144, dq=-2048 held for 4 cycles; sync only on the first.
REQ-030 Sixteen symbols 0..15 streamed with valid held high -> 64 gapless samples, sync every 4th cycle, no underrun, levels matching the Gray table.
REQ-031 Six symbols offered with din_valid held high in IDLE -> din_ready drops when the FIFO holds 4; no symbol lost or duplicated in output order.
REQ-032 Write issued on the ph=3 edge with the FIFO empty -> underrun=1, IDLE for one cycle, then the symbol emitted with sync=1.
REQ-033 rst pulsed at ph=2 with 3 symbols buffered -> outputs 0 after the edge; no buffered symbol emitted after release; din_ready=1.
